// File: rtl/arc4_pkg.sv
// ARC4 shared definitions: byte width, the CT/PT length-byte address and the
// state encoding of the PRGA/decrypt sequencer.
package arc4_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] LEN_ADDR = 8'd0;

  typedef enum logic [3:0] {
    IDLE,
    LEN_A,
    LEN_W,
    SI_A,
    SI_W,
    SJ_W,
    WR_J,
    PAD_A,
    PAD_W
  } prga_state_t;

endpackage

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation and decrypt stage. Walks the key-scheduled S
// array, swapping S[i]/S[j] per byte, and XORs each keystream byte with the
// matching ciphertext byte. The length byte at address 0 is copied straight
// through to the plaintext RAM. All RAMs are synchronous with one cycle of
// read latency, so every access takes an address state and a data state.
module arc4_prga
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [BYTE_W-1:0] s_addr,
  input  logic [BYTE_W-1:0] s_rddata,
  output logic [BYTE_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [BYTE_W-1:0] ct_addr,
  input  logic [BYTE_W-1:0] ct_rddata,
  output logic [BYTE_W-1:0] pt_addr,
  output logic [BYTE_W-1:0] pt_wrdata,
  output logic              pt_wren
);

  prga_state_t       state;
  logic [BYTE_W-1:0] i;
  logic [BYTE_W-1:0] j;
  logic [BYTE_W-1:0] len;
  logic [BYTE_W-1:0] si;
  logic [BYTE_W-1:0] sj;
  logic [BYTE_W-1:0] cb;

  // Sequencer and datapath registers; i never wraps because the length byte caps it at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      cb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            j     <= '0;
            state <= LEN_A;
          end
        end
        LEN_A: begin
          state <= LEN_W;
        end
        LEN_W: begin
          len <= ct_rddata;
          if (ct_rddata == 8'd0) begin
            state <= IDLE;
          end else begin
            i     <= 8'd1;
            state <= SI_A;
          end
        end
        SI_A: begin
          state <= SI_W;
        end
        SI_W: begin
          si    <= s_rddata;
          cb    <= ct_rddata;
          j     <= j + s_rddata;
          state <= SJ_W;
        end
        SJ_W: begin
          sj    <= s_rddata;
          state <= WR_J;
        end
        WR_J: begin
          state <= PAD_A;
        end
        PAD_A: begin
          state <= PAD_W;
        end
        PAD_W: begin
          if (i == len) begin
            state <= IDLE;
          end else begin
            i     <= i + 8'd1;
            state <= SI_A;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port drive decoded from the state; write enables depend on state only, never on RAM data.
  always_comb begin
    rdy       = (state == IDLE);
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      LEN_A: begin
        ct_addr = LEN_ADDR;
      end
      LEN_W: begin
        pt_addr   = LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      SI_A: begin
        s_addr  = i;
        ct_addr = i;
      end
      SI_W: begin
        s_addr = j + s_rddata;
      end
      SJ_W: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      PAD_A: begin
        s_addr = si + sj;
      end
      PAD_W: begin
        pt_addr   = i;
        pt_wrdata = s_rddata ^ cb;
        pt_wren   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
